// File: rtl/shift_register_sipo_rx.sv
// rtl/shift_register_sipo_rx.sv - serial-in/parallel-out receiver with strobe conditioning and frame check
// Optional SIPO_SYNC_EN: two-flop synchronizers on every input instead of a single capture flop.
module shift_register_sipo_rx #(
    parameter int WIDTH     = 7,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serialIn,
    input  logic             shiftClk,
    input  logic             latchClk,
    output logic [WIDTH-1:0] parallelOut,
    output logic             dataValid,
    output logic             frameError,
    output logic [3:0]       bitCount
);

`ifdef SIPO_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif

    localparam logic [3:0] CNT_FULL = 4'(WIDTH);
    localparam logic [3:0] CNT_MAX  = 4'd15;

    // Bit order in the pipeline: {latchClk, shiftClk, serialIn}; data rides with its strobes.
    logic [2:0] in_w;
    logic [2:0] stage_q [SYNC_STAGES];
    logic [2:0] last_w;
    logic [1:0] dly_q;
    logic       shift_edge_q;
    logic       latch_edge_q;
    logic       sin_q;

    assign in_w   = {latchClk, shiftClk, serialIn};
    assign last_w = stage_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= 3'b000;
            end
            dly_q        <= 2'b00;
            shift_edge_q <= 1'b0;
            latch_edge_q <= 1'b0;
            sin_q        <= 1'b0;
        end else begin
            stage_q[0] <= in_w;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            dly_q        <= last_w[2:1];
            shift_edge_q <= last_w[1] & ~dly_q[0];
            latch_edge_q <= last_w[2] & ~dly_q[1];
            sin_q        <= last_w[0];
        end
    end

    logic [3:0]       cnt_q, cnt_d, cnt_post;
    logic [WIDTH-1:0] sh_q, sh_d, sh_post;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             dv_q, dv_d;
    logic             fe_q, fe_d;
    logic [3:0]       bc_q;

    // The count is the frame state: 0 idle, 1..WIDTH-1 shifting, WIDTH full, above that overrun.
    always_comb begin
        cnt_post = cnt_q;
        sh_post  = sh_q;
        if (shift_edge_q) begin
            cnt_post = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
            if (LSB_FIRST) begin
                sh_post = {sin_q, sh_q[WIDTH-1:1]};
            end else begin
                sh_post = {sh_q[WIDTH-2:0], sin_q};
            end
        end

        cnt_d  = cnt_post;
        sh_d   = sh_post;
        pout_d = pout_q;
        dv_d   = 1'b0;
        fe_d   = 1'b0;
        if (latch_edge_q) begin
            if (cnt_post == CNT_FULL) begin
                pout_d = sh_post;
                dv_d   = 1'b1;
            end else begin
                fe_d = 1'b1;
            end
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= 4'd0;
            sh_q   <= '0;
            pout_q <= '0;
            dv_q   <= 1'b0;
            fe_q   <= 1'b0;
            bc_q   <= 4'd0;
        end else begin
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            pout_q <= pout_d;
            dv_q   <= dv_d;
            fe_q   <= fe_d;
            bc_q   <= cnt_q;
        end
    end

    assign parallelOut = pout_q;
    assign dataValid   = dv_q;
    assign frameError  = fe_q;
    assign bitCount    = bc_q;

endmodule

// File: tb/tb_shift_register_sipo_rx.sv
// tb/tb_shift_register_sipo_rx.sv - scoreboard bench for shift_register_sipo_rx (WIDTH=7, LSB first)
module tb_shift_register_sipo_rx;

`ifdef SIPO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       serialIn;
    logic       shiftClk;
    logic       latchClk;
    logic [6:0] parallelOut;
    logic       dataValid;
    logic       frameError;
    logic [3:0] bitCount;

    shift_register_sipo_rx #(.WIDTH(7), .LSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .serialIn   (serialIn),
        .shiftClk   (shiftClk),
        .latchClk   (latchClk),
        .parallelOut(parallelOut),
        .dataValid  (dataValid),
        .frameError (frameError),
        .bitCount   (bitCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [6:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] held;
    int         checks = 0;
    int         errors = 0;

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && (dataValid === 1'b1 || frameError === 1'b1)) begin
            exp_t e;
            checks++;
            if (dataValid && frameError) begin
                errors++;
                $display("FAIL both_pulses dataValid=%0b frameError=%0b required not both", dataValid, frameError);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse dv=%0b fe=%0b out=%h required no pulse", dataValid, frameError, parallelOut);
            end else begin
                e = exp_q.pop_front();
                if (frameError !== e.err || parallelOut !== e.data) begin
                    errors++;
                    $display("FAIL frame_result fe=%0b out=%h required fe=%0b out=%h",
                             frameError, parallelOut, e.err, e.data);
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic shift_bit(input logic b);
        serialIn = b;
        repeat (2) @(negedge clk);
        shiftClk = 1'b1;
        repeat (2) @(negedge clk);
        shiftClk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) shift_bit(bits[i]);
    endtask

    // Raise latchClk (optionally with a final shift in the same cycle) and time the result pulse.
    task automatic do_latch(input bit is_err, input logic [6:0] word, input bit with_shift, input logic sbit);
        exp_t e;
        int   lat;
        if (with_shift) begin
            serialIn = sbit;
            repeat (2) @(negedge clk);
        end
        if (!is_err) held = word;
        e.err  = is_err;
        e.data = held;
        exp_q.push_back(e);
        latchClk = 1'b1;
        if (with_shift) shiftClk = 1'b1;
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (dataValid || frameError) begin
                lat = k;
                break;
            end
        end
        check_val("latch_latency", lat, LAT);
        @(negedge clk);
        latchClk = 1'b0;
        shiftClk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset    = 1'b0;
        serialIn = 1'b0;
        shiftClk = 1'b0;
        latchClk = 1'b0;
        held     = 7'h00;
        repeat (3) @(negedge clk);
        check_val("reset_out", {parallelOut, dataValid, frameError, bitCount}, 32'h0);
        reset  = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (dataValid || frameError) pulses++;
        end
        check_val("idle_pulses", pulses, 0);

        send_bits(16'b0101100, 7);
        do_latch(1'b0, 7'h2C, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_val("bitcount_after_latch", bitCount, 0);

        send_bits(16'b10110, 5);
        do_latch(1'b1, 7'h00, 1'b0, 1'b0);

        send_bits(16'b1_0110_1001, 9);
        repeat (4) @(negedge clk);
        check_val("bitcount_overrun", bitCount, 9);
        do_latch(1'b1, 7'h00, 1'b0, 1'b0);

        do_latch(1'b1, 7'h00, 1'b0, 1'b0);

        send_bits(16'b100101, 6);
        do_latch(1'b0, 7'h65, 1'b1, 1'b1);

        send_bits(16'b1111, 4);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midframe_reset_out", {parallelOut, bitCount}, 32'h0);
        held  = 7'h00;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_bits(16'h55, 7);
        do_latch(1'b0, 7'h55, 1'b0, 1'b0);

        send_bits(16'h7F, 7);
        do_latch(1'b0, 7'h7F, 1'b0, 1'b0);
        send_bits(16'h00, 7);
        do_latch(1'b0, 7'h00, 1'b0, 1'b0);

        repeat (6) @(negedge clk);
        check_val("final_bitcount", bitCount, 0);
        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
